// File: rtl/intersection_pkg.sv
// Shared encodings for the intersection right-of-way arbiter: FSM states,
// one-hot lamp codes and approach identifiers.
package intersection_pkg;

  typedef enum logic [2:0] {
    ALLRED = 3'd0,
    G1     = 3'd1,
    Y1     = 3'd2,
    G2     = 3'd3,
    Y2     = 3'd4,
    WALK   = 3'd5,
    FLASH  = 3'd6,
    EMER   = 3'd7
  } state_t;

  localparam logic [2:0] RED    = 3'd1;
  localparam logic [2:0] YELLOW = 3'd2;
  localparam logic [2:0] GREEN  = 3'd4;

  localparam logic [1:0] GO_T1 = 2'd1;
  localparam logic [1:0] GO_T2 = 2'd2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times each phase; holds at zero until reloaded.
module phase_timer #(
  parameter int           W         = 4,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/intersection_phase_arbiter.sv
// Single-green scheduler for two approaches with pedestrian walk insertion
// and emergency pre-emption; lamps decode straight from the state register.
module intersection_phase_arbiter
  import intersection_pkg::*;
#(
  parameter int GREEN_T  = 30,
  parameter int YELLOW_T = 5,
  parameter int ALLRED_T = 2,
  parameter int WALK_T   = 20,
  parameter int FLASH_T  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req1,
  input  logic       req2,
  input  logic       pedButton,
  input  logic       emergency,
  output logic [2:0] T1,
  output logic [2:0] T2,
  output logic       Walk,
  output logic       Buzzer,
  output logic [2:0] phase
);

  localparam int MAX_D = max_int(max_int(max_int(GREEN_T, YELLOW_T),
                                         max_int(ALLRED_T, WALK_T)), FLASH_T);
  localparam int TW = $clog2(MAX_D) + 1;

  state_t          state, state_nx;
  logic [1:0]      next_go, next_go_nx;
  logic            ped_pending;
  logic            rest_reload;
  logic            tmr_load, tmr_zero;
  logic [TW-1:0]   tmr_val;

  function automatic logic [TW-1:0] dwell(input state_t s);
    case (s)
      G1, G2:  return TW'(GREEN_T - 1);
      Y1, Y2:  return TW'(YELLOW_T - 1);
      WALK:    return TW'(WALK_T - 1);
      FLASH:   return TW'(FLASH_T - 1);
      ALLRED:  return TW'(ALLRED_T - 1);
      default: return '0;
    endcase
  endfunction

  phase_timer #(
    .W         (TW),
    .RESET_VAL (TW'(ALLRED_T - 1))
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ALLRED;
      next_go     <= GO_T1;
      ped_pending <= 1'b0;
    end else begin
      state   <= state_nx;
      next_go <= next_go_nx;
      // Entering WALK consumes the request and beats a same-cycle press.
      if (state_nx == WALK && state != WALK) begin
        ped_pending <= 1'b0;
      end else if (pedButton && state != WALK && state != FLASH) begin
        ped_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    next_go_nx  = next_go;
    rest_reload = 1'b0;
    case (state)
      ALLRED: if (tmr_zero) begin
        if (emergency)             state_nx = EMER;
        else if (ped_pending)      state_nx = WALK;
        else if (next_go == GO_T1) state_nx = G1;
        else                       state_nx = G2;
      end
      G1: begin
        if (emergency)                       state_nx = Y1;
        else if (tmr_zero && (req2 || ped_pending)) state_nx = Y1;
        else if (tmr_zero)                   rest_reload = 1'b1;
      end
      G2: begin
        if (emergency)                       state_nx = Y2;
        else if (tmr_zero && (req1 || ped_pending)) state_nx = Y2;
        else if (tmr_zero)                   rest_reload = 1'b1;
      end
      Y1: if (tmr_zero) begin
        state_nx   = ALLRED;
        next_go_nx = GO_T2;
      end
      Y2: if (tmr_zero) begin
        state_nx   = ALLRED;
        next_go_nx = GO_T1;
      end
      WALK:    if (emergency || tmr_zero) state_nx = FLASH;
      FLASH:   if (tmr_zero) state_nx = ALLRED;
      EMER:    if (!emergency) state_nx = ALLRED;
      default: state_nx = ALLRED;
    endcase
    // Any state change or a green rest starts a fresh full dwell.
    tmr_load = (state_nx != state) || rest_reload;
    tmr_val  = dwell(state_nx);
  end

  always_comb begin
    T1     = RED;
    T2     = RED;
    Walk   = 1'b0;
    Buzzer = 1'b0;
    case (state)
      G1:      T1 = GREEN;
      Y1:      T1 = YELLOW;
      G2:      T2 = GREEN;
      Y2:      T2 = YELLOW;
      WALK:    Walk = 1'b1;
      FLASH: begin
        Walk   = 1'b1;
        Buzzer = 1'b1;
      end
      EMER:    Buzzer = 1'b1;
      default: ;
    endcase
  end

  assign phase = state;

endmodule

// File: doc/intersection_phase_arbiter.md
# intersection_phase_arbiter

Right-of-way arbiter for a two-approach intersection. It owns the single green resource and grants it alternately to approach T1 and approach T2. It inserts an all-red pedestrian walk phase on demand and pre-empts everything for emergency vehicles. It replaces the two independent per-approach light sequencers with one scheduler, so conflicting greens are impossible by construction.

## Interface
- `GREEN_T`, 30: minimum green dwell, in clk cycles.
- `YELLOW_T`, 5: yellow dwell.
- `ALLRED_T`, 2: all-red clearance dwell.
- `WALK_T`, 20: pedestrian walk dwell.
- `FLASH_T`, 5: walk-ending warning dwell (walk plus buzzer).
- `clk` in 1: single clock; one cycle is one time unit.
- `reset` in 1: **asynchronous, active-low** reset.
- `req1` in 1: vehicle demand on T1 (level).
- `req2` in 1: vehicle demand on T2 (level).
- `pedButton` in 1: pedestrian request (level, synchronous).
- `emergency` in 1: emergency pre-emption (level, synchronous).
- `T1` out 3: T1 light, one-hot: RED=3'd1, YELLOW=3'd2, GREEN=3'd4.
- `T2` out 3: T2 light, same encoding.
- `Walk` out 1: walk indication.
- `Buzzer` out 1: audible warning.
- `phase` out 3: current state encoding, for debug and monitors.

## Operation
- The FSM state register holds one of these states: ALLRED=0, G1=1, Y1=2, G2=3, Y2=4, WALK=5, FLASH=6, EMER=7.
- Phase timer:
  - loads `D-1` on entry to each timed state, where D is that state's dwell;
  - decrements every cycle;
  - "expiry" means timer==0.
- Internal registers:
  - `nextGo`: which approach gets the next green; 1 for T1, 2 for T2.
  - `pedPending`: latched pedestrian request.
- ALLRED, on expiry, evaluated in priority order:
  1. `emergency` → EMER;
  2. `pedPending` → WALK;
  3. `nextGo==1` → G1;
  4. otherwise → G2.
- G1, on expiry:
  - if `req2|pedPending` → Y1;
  - otherwise reload `GREEN_T` and rest in green.
- G2 is symmetric, using `req1`.
- Y1, on expiry → ALLRED and set `nextGo=2`. Y2, on expiry → ALLRED and set `nextGo=1`.
- WALK, on expiry → FLASH. FLASH, on expiry → ALLRED. `nextGo` is unchanged across the walk phase.
- `pedPending`:
  - set on any cycle with `pedButton=1` while not in WALK or FLASH;
  - cleared on the edge entering WALK; clearing wins over a simultaneous press;
  - presses during WALK or FLASH are ignored.
- `emergency` asserted:
  - in G1 or G2: go to Y1 or Y2 on the next edge, minimum green is abandoned;
  - in WALK: go to FLASH on the next edge;
  - in Y1, Y2, FLASH or ALLRED: the current dwell completes normally;
  - EMER is held while `emergency=1`;
  - on deassert: EMER → ALLRED with a full clearance.
  - `pedPending` and `nextGo` are preserved across pre-emption.
- Output decode:
  - ALLRED, WALK, FLASH and EMER: `T1=T2=RED`.
  - G1, Y1: T1=GREEN/YELLOW, T2=RED.
  - G2, Y2: mirrored.
  - `Walk`: 1 in WALK and FLASH only.
  - `Buzzer`: 1 in FLASH and EMER only.
- Invariants:
  - `T1` and `T2` are never simultaneously non-RED;
  - every GREEN is preceded by ALLRED;
  - `Walk=1` only when both approaches are RED.

## Timing
- Reset asserted puts the block immediately into:
  - state ALLRED, timer=`ALLRED_T-1`, `nextGo=1`, `pedPending=0`;
  - outputs `T1=T2=RED`, `Walk=0`, `Buzzer=0`, `phase=0`.
- Reset asserted mid-operation aborts any phase asynchronously. There is no yellow on reset.
- Outputs are decoded directly from the state register. They change on the same edge as `phase`, with zero additional latency.
- Inputs are sampled on rising `clk`. An input change affects the state on the next edge.
- Timed-state occupancy is exactly D cycles, counting a reloaded green as a fresh D.
- Timer width is `$clog2(max(all dwells))+1`.
- All dwell parameters must be ≥1. A dwell of 1 gives single-cycle occupancy.

## Structure
- Package `intersection_pkg`:
  - state encodings (ALLRED…EMER);
  - light constants RED/YELLOW/GREEN;
  - approach IDs for `nextGo`.
- Sub-module `phase_timer`: loadable down-counter with ports load, load value, and zero flag. The FSM, request latch and output decode live in the top module.

## Test plan
All scenarios use default parameters. Cycle n is the n-th rising edge after reset deassert, starting at n=0.

1. `req2=1` constant, other inputs 0:
   - ALLRED for n=0–1;
   - G1 for 2–31;
   - Y1 for 32–36;
   - ALLRED for 37–38;
   - G2 at n=39.
2. No requests:
   - G1 entered at n=2 and held indefinitely;
   - `T2` stays RED.
3. `pedButton` pulsed 1 cycle at n=10:
   - G1 until 31, Y1 until 36, ALLRED until 38;
   - WALK for 39–58 with `Walk=1`;
   - FLASH for 59–63 with `Walk=Buzzer=1`;
   - ALLRED for 64–65, then G2.
4. `emergency` asserted at n=15 and released at n=60:
   - Y1 from n=16 for 5 cycles;
   - ALLRED for 2 cycles;
   - EMER with `Buzzer=1` and both RED until release;
   - ALLRED for 2 cycles, then G2.
5. Press `pedButton` during WALK:
   - no second walk phase occurs.
   - Separately, a press coincident with WALK entry leaves `pedPending=0`.
6. Reset asserted during G2:
   - all outputs return to reset values immediately, asynchronously;
   - after release, G1 is entered after 2 cycles.
